// File: rtl/eth_frame_src_pkg.sv
// rtl/eth_frame_src_pkg.sv - shared state type, EtherType constants and last-beat keep helper
package eth_frame_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

  // Keep mask of the final beat; a zero remainder means the final beat is full.
  function automatic logic [7:0] last_keep_mask(input logic [15:0] len, input int kw);
    logic [7:0] mask;
    int rem;
    rem  = int'(len) % kw;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (i < kw) && ((rem == 0) || (i < rem));
    end
    return mask;
  endfunction

endpackage

// File: rtl/eth_frame_src_buf.sv
// rtl/eth_frame_src_buf.sv - DEPTH x DATA_WIDTH simple dual-port payload RAM, registered read
module eth_frame_src_buf #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_frame_src.sv
// rtl/eth_frame_src.sv - command-driven Ethernet header + buffered payload stream source
// Optional ETH_FRAME_SRC_TUSER_INJECT_EN adds cmd_bad, reported on tuser of the last beat.
module eth_frame_src
  import eth_frame_src_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16,
  parameter int IFG_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [47:0]           cmd_dest_mac,
  input  logic [47:0]           cmd_src_mac,
  input  logic [15:0]           cmd_eth_type,
  input  logic [15:0]           cmd_len,
`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
  input  logic                  cmd_bad,
`endif
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  err_len,
  output logic                  err_ovf
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          KW_LOG   = $clog2(KEEP_WIDTH);
  localparam logic [31:0] MAX_LEN  = 32'(DEPTH * KEEP_WIDTH);
  localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);
  localparam logic [3:0]  GAP_LAST = 4'(IFG_CYCLES - 1);

  state_t                state_q, state_d;
  logic [47:0]           dest_q, dest_d, src_q, src_d;
  logic [15:0]           type_q, type_d, len_q, len_d;
  logic [AW-1:0]         last_idx_q, last_idx_d, beat_q, beat_d;
  logic [3:0]            gap_q, gap_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  logic                  hdr_valid_q, hdr_valid_d, tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d, tuser_q, tuser_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                  bad_q;

  logic                  accept, len_ok, hdr_hs, beat_hs, wr_do;
  logic [AW-1:0]         beat_nxt, rd_addr;
  logic [KEEP_WIDTH-1:0] keep_last;
  logic [DATA_WIDTH-1:0] rd_data;

`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
  logic bad_d;
  always_comb begin
    bad_d = bad_q;
    if (accept && len_ok) begin
      bad_d = cmd_bad;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) bad_q <= 1'b0;
    else      bad_q <= bad_d;
  end
`else
  assign bad_q = 1'b0;
`endif

  assign accept    = cmd_valid && cmd_ready_q;
  assign len_ok    = (cmd_len != 16'd0) && ({16'd0, cmd_len} <= MAX_LEN);
  assign hdr_hs    = hdr_valid_q && m_eth_hdr_ready;
  assign beat_hs   = tvalid_q && m_eth_payload_axis_tready;
  assign wr_do     = (state_q == ST_IDLE) && wr_en && (wr_ptr_q != PTR_FULL);
  assign beat_nxt  = beat_q + AW'(1);
  assign keep_last = KEEP_WIDTH'(last_keep_mask(len_q, KEEP_WIDTH));

  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    src_d         = src_q;
    type_d        = type_q;
    len_d         = len_q;
    last_idx_d    = last_idx_q;
    beat_d        = beat_q;
    gap_d         = gap_q;
    wr_ptr_d      = wr_ptr_q;
    frame_count_d = frame_count_q;
    err_len_d     = 1'b0;
    err_ovf_d     = err_ovf_q;
    hdr_valid_d   = hdr_valid_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tkeep_d       = tkeep_q;
    tuser_d       = tuser_q;
    rd_addr       = '0;

    if (wr_do) begin
      wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end
    if ((state_q == ST_IDLE) && wr_en && (wr_ptr_q == PTR_FULL)) begin
      err_ovf_d = 1'b1;
    end

    // The RAM address always tracks the beat presented next cycle, so rd_data
    // already holds the current beat and handshakes can run back-to-back.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_ptr_d = '0;
          if (len_ok) begin
            dest_d      = cmd_dest_mac;
            src_d       = cmd_src_mac;
            type_d      = cmd_eth_type;
            len_d       = cmd_len;
            last_idx_d  = AW'((cmd_len - 16'd1) >> KW_LOG);
            beat_d      = '0;
            hdr_valid_d = 1'b1;
            state_d     = ST_HDR;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (hdr_hs) begin
          hdr_valid_d = 1'b0;
          tvalid_d    = 1'b1;
          tlast_d     = (last_idx_q == '0);
          tkeep_d     = (last_idx_q == '0) ? keep_last : '1;
          tuser_d     = (last_idx_q == '0) && bad_q;
          state_d     = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        rd_addr = beat_q;
        if (beat_hs) begin
          if (tlast_q) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            tuser_d       = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
            gap_d         = '0;
            state_d       = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            beat_d  = beat_nxt;
            rd_addr = beat_nxt;
            tlast_d = (beat_nxt == last_idx_q);
            tkeep_d = (beat_nxt == last_idx_q) ? keep_last : '1;
            tuser_d = (beat_nxt == last_idx_q) && bad_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      dest_q        <= '0;
      src_q         <= '0;
      type_q        <= '0;
      len_q         <= '0;
      last_idx_q    <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      wr_ptr_q      <= '0;
      frame_count_q <= '0;
      err_len_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      hdr_valid_q   <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tkeep_q       <= '0;
      tuser_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_q        <= dest_d;
      src_q         <= src_d;
      type_q        <= type_d;
      len_q         <= len_d;
      last_idx_q    <= last_idx_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_count_q <= frame_count_d;
      err_len_q     <= err_len_d;
      err_ovf_q     <= err_ovf_d;
      hdr_valid_q   <= hdr_valid_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tkeep_q       <= tkeep_d;
      tuser_q       <= tuser_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  eth_frame_src_buf #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_do),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign cmd_ready                 = cmd_ready_q;
  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = rd_data;
  assign m_eth_payload_axis_tkeep  = tkeep_q;
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast_q;
  assign m_eth_payload_axis_tuser  = tuser_q;
  assign busy                      = busy_q;
  assign frame_count               = frame_count_q;
  assign err_len                   = err_len_q;
  assign err_ovf                   = err_ovf_q;

endmodule

// File: tb/tb_eth_frame_src.sv
// tb/tb_eth_frame_src.sv - scoreboard bench for eth_frame_src (DATA_WIDTH=64, DEPTH=16, IFG_CYCLES=3)
// Builds with or without ETH_FRAME_SRC_TUSER_INJECT_EN.
module tb_eth_frame_src;

  localparam int IFG = 3;
`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
  localparam bit TUSER_EN = 1'b1;
  logic cmd_bad;
`else
  localparam bit TUSER_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
  } hdr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        cmd_valid, cmd_ready;
  logic [47:0] cmd_dest_mac, cmd_src_mac;
  logic [15:0] cmd_eth_type, cmd_len;
  logic        m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast, tuser;
  logic        busy, err_len, err_ovf;
  logic [15:0] frame_count;

  beat_t       exp_q[$];
  hdr_t        hdr_q[$];
  bit          rdy_q[$];
  logic [63:0] m_mem[16];
  int          m_wptr = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          waited;

  always #5 clk = ~clk;

  eth_frame_src #(
    .DATA_WIDTH (64),
    .KEEP_WIDTH (8),
    .DEPTH      (16),
    .IFG_CYCLES (IFG)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .wr_en                     (wr_en),
    .wr_data                   (wr_data),
    .cmd_valid                 (cmd_valid),
    .cmd_ready                 (cmd_ready),
    .cmd_dest_mac              (cmd_dest_mac),
    .cmd_src_mac               (cmd_src_mac),
    .cmd_eth_type              (cmd_eth_type),
    .cmd_len                   (cmd_len),
`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
    .cmd_bad                   (cmd_bad),
`endif
    .m_eth_hdr_valid           (m_eth_hdr_valid),
    .m_eth_hdr_ready           (m_eth_hdr_ready),
    .m_eth_dest_mac            (m_eth_dest_mac),
    .m_eth_src_mac             (m_eth_src_mac),
    .m_eth_type                (m_eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tkeep  (tkeep),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .frame_count               (frame_count),
    .err_len                   (err_len),
    .err_ovf                   (err_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", cmd_ready, 1);
  endtask

  task automatic wr_beat(input logic [63:0] d);
    wr_en = 1'b1;
    wr_data = d;
    if (m_wptr < 16) begin
      m_mem[m_wptr] = d;
      m_wptr++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issues one command; optionally writes a beat in the same cycle. Returns cycles spent waiting.
  task automatic send_cmd(input int len, input logic bad, input logic with_wr,
                          input logic [63:0] wd, output int wt);
    hdr_t h;
    beat_t b;
    int nb;
    int rem;
    h.dest  = 48'({$urandom, $urandom});
    h.src   = 48'({$urandom, $urandom});
    h.etype = ($urandom_range(0, 1) == 0) ? 16'h0800 : 16'h0806;
    cmd_valid    = 1'b1;
    cmd_dest_mac = h.dest;
    cmd_src_mac  = h.src;
    cmd_eth_type = h.etype;
    cmd_len      = 16'(len);
`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
    cmd_bad = bad;
`endif
    if (with_wr) begin
      wr_en = 1'b1;
      wr_data = wd;
    end
    wt = 0;
    @(negedge clk);
    while (!cmd_ready && wt < 200) begin
      wt++;
      @(negedge clk);
    end
    check("cmd_ready_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wr_en = 1'b0;
    if (with_wr && m_wptr < 16) m_mem[m_wptr] = wd;
    m_wptr = 0;
    if (len >= 1 && len <= 128) begin
      hdr_q.push_back(h);
      nb  = (len + 7) / 8;
      rem = len % 8;
      for (int i = 0; i < nb; i++) begin
        b.data = m_mem[i];
        b.last = (i == nb - 1);
        b.keep = (b.last && rem != 0) ? (8'hFF >> (8 - rem)) : 8'hFF;
        b.user = b.last && bad && TUSER_EN;
        exp_q.push_back(b);
      end
    end
  endtask

  // Consumes header and payload until tlast handshake or max_beats handshakes.
  task automatic collect(input int max_beats);
    int got = 0;
    bit stalled = 0, done = 0, fin = 0, hrdy_nxt;
    beat_t prev, e;
    hdr_t h;
    m_eth_hdr_ready = 1'b0;
    for (int t = 0; t < 600 && !fin; t++) begin
      tready = (tvalid && rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      @(negedge clk);
      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
        if (hdr_q.size() == 0) check("hdr_extra", 1, 0);
        else begin
          h = hdr_q.pop_front();
          check("hdr_dest", m_eth_dest_mac, h.dest);
          check("hdr_src", m_eth_src_mac, h.src);
          check("hdr_type", m_eth_type, h.etype);
        end
      end
      hrdy_nxt = m_eth_hdr_valid && !m_eth_hdr_ready;
      if (stalled) begin
        check("stall_valid", tvalid, 1);
        check("stall_data", tdata, prev.data);
        check("stall_keep", tkeep, prev.keep);
        check("stall_last", tlast, prev.last);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) check("beat_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", tdata, e.data);
          check("beat_keep", tkeep, e.keep);
          check("beat_last", tlast, e.last);
          check("beat_user", tuser, e.user);
        end
        got++;
        stalled = 0;
        if (tlast) done = 1;
      end else if (tvalid) begin
        stalled   = 1;
        prev.data = tdata;
        prev.keep = tkeep;
        prev.last = tlast;
      end
      @(posedge clk); #1;
      m_eth_hdr_ready = hrdy_nxt;
      fin = done || (got == max_beats);
    end
    if (!fin) check("collect_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; cmd_valid = 1'b0;
    cmd_dest_mac = '0; cmd_src_mac = '0; cmd_eth_type = '0; cmd_len = '0;
    m_eth_hdr_ready = 1'b0; tready = 1'b1;
`ifdef ETH_FRAME_SRC_TUSER_INJECT_EN
    cmd_bad = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_hdr_valid", m_eth_hdr_valid, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_len", err_len, 0);
    check("rst_err_ovf", err_ovf, 0);
    @(posedge clk); #1;

    // 28-byte frame: 4 beats, last keep 0x0F; final beat written alongside the command
    for (int i = 0; i < 3; i++) wr_beat({$urandom, $urandom});
    send_cmd(28, 1'b0, 1'b1, {$urandom, $urandom}, waited);
    collect(99);
    check("fc_after_1", frame_count, 1);
    check("busy_in_gap", busy, 1);
    wr_en = 1'b1; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("gap_write_no_ovf", err_ovf, 0);

    // 3-beat frame (20 bytes) under tready 1,0,0,1,0,1
    wait_idle();
    for (int i = 0; i < 3; i++) wr_beat({$urandom, $urandom});
    rdy_q = '{1, 0, 0, 1, 0, 1};
    send_cmd(20, 1'b0, 1'b0, '0, waited);
    collect(99);
    check("fc_after_2", frame_count, 2);
    check("q_empty_2", exp_q.size(), 0);

    // illegal lengths 0 and 129
    send_cmd(0, 1'b0, 1'b0, '0, waited);
    check("len0_err_pulse", err_len, 1);
    check("len0_hdr_valid", m_eth_hdr_valid, 0);
    check("len0_busy", busy, 0);
    @(posedge clk); #1;
    check("len0_err_clear", err_len, 0);
    send_cmd(129, 1'b0, 1'b0, '0, waited);
    check("len129_err_pulse", err_len, 1);
    check("len129_busy", busy, 0);
    @(posedge clk); #1;
    check("len129_err_clear", err_len, 0);
    check("len129_hdr_valid", m_eth_hdr_valid, 0);
    check("fc_after_err", frame_count, 2);

    // 17 writes overflow; then a full 128-byte frame
    for (int i = 0; i < 16; i++) wr_beat({$urandom, $urandom});
    check("ovf_at_16", err_ovf, 0);
    wr_beat(64'h0123_4567_89AB_CDEF);
    check("ovf_at_17", err_ovf, 1);
    send_cmd(128, 1'b0, 1'b0, '0, waited);
    collect(99);
    check("fc_after_full", frame_count, 3);
    check("ovf_sticky", err_ovf, 1);

    // two queued commands: gap length, then tuser on last beat only
    wait_idle();
    for (int i = 0; i < 2; i++) wr_beat({$urandom, $urandom});
    send_cmd(12, 1'b1, 1'b0, '0, waited);
    collect(99);
    send_cmd(16, 1'b0, 1'b0, '0, waited);
    check("ifg_cycles", waited, IFG);
    collect(99);
    check("fc_after_pair", frame_count, 5);

    // reset while beat 1 of a 3-beat frame is pending
    wait_idle();
    for (int i = 0; i < 3; i++) wr_beat({$urandom, $urandom});
    send_cmd(24, 1'b0, 1'b0, '0, waited);
    collect(1);
    tready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("beat1_pending", tvalid, 1);
    check("beat1_not_last", tlast, 0);
    @(posedge clk); #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_fc", frame_count, 0);
    check("mid_rst_ovf", err_ovf, 0);
    rst = 1'b1;
    tready = 1'b1;
    exp_q.delete();
    hdr_q.delete();
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_tvalid", tvalid, 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
